// File: rtl/manual_loader_if.sv
// manual_loader_if: key, switch and memory-write signals of the manual word loader
interface manual_loader_if #(parameter int ADDR_WIDTH = 13);
  logic data_key;
  logic addr_key;
  logic [15:0] data;
  logic wr_ack;
  logic wr_en;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0] wr_data;
  logic [1:0] state;
  logic [15:0] count;
  modport master(input data_key, addr_key, data, wr_ack, output wr_en, addr, wr_data, state, count);
  modport slave(output data_key, addr_key, data, wr_ack, input wr_en, addr, wr_data, state, count);
endinterface

// File: rtl/manual_loader.sv
// manual_loader: debounced push-buttons assemble 32-bit words from 16-bit switches and write them to memory
module manual_loader #(
  parameter int ADDR_WIDTH = 13,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input logic clk,
  input logic rst,
  manual_loader_if.master bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  typedef enum logic [1:0] {S_LO = 2'd0, S_HI = 2'd1, S_WR = 2'd2} state_t;
  state_t state, state_n;
  logic [1:0] raw, meta, sync, level, ev;
  logic [CW-1:0] cnt [2];
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0] wr_data;
  logic [15:0] count;
  assign raw = {bus.addr_key, bus.data_key};
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '1;
      sync <= '1;
    end else begin
      meta <= raw;
      sync <= meta;
    end
  end
  // bit 0 is the data key, bit 1 the address key; ev pulses once per accepted press
  always_ff @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        cnt[k] <= '0;
        level[k] <= 1'b1;
        ev[k] <= 1'b0;
      end else begin
        ev[k] <= 1'b0;
        if (sync[k] == level[k]) cnt[k] <= '0;
        else if (cnt[k] == CW'(DEBOUNCE_CYCLES - 1)) begin
          cnt[k] <= '0;
          level[k] <= sync[k];
          ev[k] <= ~sync[k];
        end else cnt[k] <= cnt[k] + 1'b1;
      end
    end
  end
  always_ff @(posedge clk) state <= rst ? S_LO : state_n;
  always_comb begin
    state_n = state;
    state_n = (state == S_LO && ev[0]) ? S_HI :
              (state == S_HI && ev[0]) ? S_WR :
              (state == S_WR && bus.wr_ack) ? S_LO : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
      wr_data <= '0;
      count <= '0;
    end else begin
      if (state == S_LO && ev[0]) wr_data[15:0] <= bus.data;
      if (state == S_LO && ev[1] && !ev[0]) addr <= ADDR_WIDTH'(bus.data);
      if (state == S_HI && ev[0]) wr_data[31:16] <= bus.data;
      if (state == S_WR && bus.wr_ack) begin
        addr <= addr + 1'b1;
        count <= count + 1'b1;
      end
    end
  end
  assign bus.wr_en = (state == S_WR);
  assign bus.state = state;
  assign bus.addr = addr;
  assign bus.wr_data = wr_data;
  assign bus.count = count;
endmodule

// File: tb/tb_manual_loader.sv
// tb_manual_loader: vector table, hand-written corner sequences and random transactions against a word-level model
module tb_manual_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  manual_loader_if #(.ADDR_WIDTH(13)) bus();
  manual_loader #(.ADDR_WIDTH(13), .DEBOUNCE_CYCLES(4)) dut (.clk(clk), .rst(rst), .bus(bus.master));
  always #5 clk = ~clk;
  typedef struct {
    int op;
    logic [15:0] v;
    logic [1:0] st;
    logic [12:0] addr;
    logic [31:0] wd;
    logic [15:0] cnt;
  } vec_t;
  vec_t tbl [11];
  int m_state;
  logic [12:0] m_addr;
  logic [31:0] m_data;
  logic [15:0] m_count;
  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  task automatic check_all(string tag, int st, logic [12:0] a, logic [31:0] wd, logic [15:0] c);
    check({tag, ".state"}, 32'(bus.state), 32'(st));
    check({tag, ".wr_en"}, 32'(bus.wr_en), 32'(st == 2));
    check({tag, ".addr"}, 32'(bus.addr), 32'(a));
    check({tag, ".wr_data"}, bus.wr_data, wd);
    check({tag, ".count"}, 32'(bus.count), 32'(c));
  endtask
  task automatic press(bit is_addr, logic [15:0] v);
    bus.data = v;
    if (is_addr) bus.addr_key = 1'b0;
    else bus.data_key = 1'b0;
    tick(10);
    bus.data_key = 1'b1;
    bus.addr_key = 1'b1;
    tick(10);
  endtask
  task automatic ack();
    bus.wr_ack = 1'b1;
    tick(1);
    bus.wr_ack = 1'b0;
    tick(3);
  endtask
  task automatic do_op(int op, logic [15:0] v);
    if (op == 0) press(1'b0, v);
    else if (op == 1) press(1'b1, v);
    else ack();
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    m_state = 0;
    m_addr = '0;
    m_data = '0;
    m_count = '0;
  endtask
  // word-level model: one call per button press or ack pulse
  task automatic model_op(int op, logic [15:0] v);
    if (op == 0 && m_state == 0) begin
      m_data[15:0] = v;
      m_state = 1;
    end else if (op == 0 && m_state == 1) begin
      m_data[31:16] = v;
      m_state = 2;
    end else if (op == 1 && m_state == 0) m_addr = v[12:0];
    else if (op == 2 && m_state == 2) begin
      m_state = 0;
      m_addr = m_addr + 13'd1;
      m_count = m_count + 16'd1;
    end
  endtask
  initial begin
    bit bad;
    logic [31:0] hold_wd;
    bus.data_key = 1'b1;
    bus.addr_key = 1'b1;
    bus.data = '0;
    bus.wr_ack = 1'b0;
    tbl[0] = '{0, 16'h5678, 2'd1, 13'h0000, 32'h0000_5678, 16'd0};
    tbl[1] = '{0, 16'h1234, 2'd2, 13'h0000, 32'h1234_5678, 16'd0};
    tbl[2] = '{2, 16'h0000, 2'd0, 13'h0001, 32'h1234_5678, 16'd1};
    tbl[3] = '{2, 16'h0000, 2'd0, 13'h0001, 32'h1234_5678, 16'd1};
    tbl[4] = '{1, 16'h1FFF, 2'd0, 13'h1FFF, 32'h1234_5678, 16'd1};
    tbl[5] = '{0, 16'hAAAA, 2'd1, 13'h1FFF, 32'h1234_AAAA, 16'd1};
    tbl[6] = '{1, 16'h0042, 2'd1, 13'h1FFF, 32'h1234_AAAA, 16'd1};
    tbl[7] = '{0, 16'hBBBB, 2'd2, 13'h1FFF, 32'hBBBB_AAAA, 16'd1};
    tbl[8] = '{0, 16'hCCCC, 2'd2, 13'h1FFF, 32'hBBBB_AAAA, 16'd1};
    tbl[9] = '{2, 16'h0000, 2'd0, 13'h0000, 32'hBBBB_AAAA, 16'd2};
    tbl[10] = '{1, 16'hE005, 2'd0, 13'h0005, 32'hBBBB_AAAA, 16'd2};
    do_reset();
    check_all("reset", 0, 13'h0, 32'h0, 16'h0);
    for (int i = 0; i < 11; i++) begin
      do_op(tbl[i].op, tbl[i].v);
      check_all($sformatf("vec%0d", i), int'(tbl[i].st), tbl[i].addr, tbl[i].wd, tbl[i].cnt);
    end
    do_reset();
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.data_key = 1'b0;
      tick(1);
      bad |= (bus.state != 2'd0);
      tick(1);
      bad |= (bus.state != 2'd0);
      bus.data_key = 1'b1;
      tick(1);
      bad |= (bus.state != 2'd0);
      tick(1);
      bad |= (bus.state != 2'd0);
    end
    check("bounce.no_early_event", 32'(bad), 32'd0);
    bus.data_key = 1'b0;
    tick(10);
    bus.data_key = 1'b1;
    tick(10);
    check("bounce.one_event", 32'(bus.state), 32'd1);
    do_reset();
    press(1'b1, 16'h0123);
    bus.data = 16'h00AA;
    bus.data_key = 1'b0;
    bus.addr_key = 1'b0;
    tick(10);
    bus.data_key = 1'b1;
    bus.addr_key = 1'b1;
    tick(10);
    check("simul.lo_half", 32'(bus.wr_data[15:0]), 32'h00AA);
    check("simul.addr", 32'(bus.addr), 32'h0123);
    check("simul.state", 32'(bus.state), 32'd1);
    press(1'b0, 16'h5555);
    hold_wd = 32'h5555_00AA;
    check("hold.enter_wr", 32'(bus.wr_en), 32'd1);
    bad = 1'b0;
    for (int p = 0; p < 3; p++) begin
      bus.data = 16'($urandom);
      bus.data_key = 1'b0;
      for (int i = 0; i < 8; i++) begin
        tick(1);
        bad |= (bus.wr_en !== 1'b1);
      end
      bus.data_key = 1'b1;
      for (int i = 0; i < 8; i++) begin
        tick(1);
        bad |= (bus.wr_en !== 1'b1);
      end
    end
    tick(2);
    check("hold.wr_en_held", 32'(bad), 32'd0);
    check("hold.data_stable", bus.wr_data, hold_wd);
    ack();
    tick(10);
    check("hold.after_ack_state", 32'(bus.state), 32'd0);
    check("hold.after_ack_data", bus.wr_data, hold_wd);
    check("hold.after_ack_addr", 32'(bus.addr), 32'h0124);
    press(1'b0, 16'h1111);
    press(1'b0, 16'h2222);
    check("rstwr.pre_wr_en", 32'(bus.wr_en), 32'd1);
    check("rstwr.pre_count", 32'(bus.count), 32'd1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_all("rstwr", 0, 13'h0, 32'h0, 16'h0);
    bus.data = 16'h7777;
    bus.data_key = 1'b0;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(3);
    check("heldkey.no_early", 32'(bus.state), 32'd0);
    tick(7);
    check("heldkey.late_event", 32'(bus.state), 32'd1);
    bus.data_key = 1'b1;
    tick(10);
    do_reset();
    for (int i = 0; i < 40; i++) begin
      int op;
      logic [15:0] v;
      op = int'($urandom_range(0, 2));
      v = 16'($urandom);
      do_op(op, v);
      model_op(op, v);
      check_all($sformatf("rnd%0d", i), m_state, m_addr, m_data, m_count);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/manual_loader.md
MANUAL_LOADER -- requirements
Module: manual_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 13: width of the memory word address.
REQ-002 Parameter DEBOUNCE_CYCLES, default 500000: consecutive stable cycles required to accept a key level change (10 ms at 50 MHz).
REQ-003 iClock  input  1: sole clock; all state updates on its rising edge.
REQ-004 iReset  input  1: synchronous, active-high reset.
REQ-005 iDataKey  input  1: raw push-button, active-low, asynchronous to iClock; a press enters one 16-bit half-word.
REQ-006 iAddrKey  input  1: raw push-button, active-low, asynchronous; a press loads the write address.
REQ-007 iData  input  16: switch value, half-word or address source.
REQ-008 iWrAck  input  1: memory write acknowledge, valid only while oWrEn=1.
REQ-009 oWrEn  output  1: write request, held until acknowledged.
REQ-010 oAddr  output  ADDR_WIDTH: current write address.
REQ-011 oWrData  output  32: assembled word {high half, low half}.
REQ-012 oState  output  2: state code for the 7-segment debug mux: 0=S_LO, 1=S_HI, 2=S_WR.
REQ-013 oCount  output  16: number of words written since reset, wraps 0xFFFF->0.

Function
REQ-014 Each key SHALL pass through a 2-flop synchronizer before any other logic.
REQ-015 Debouncer per key: the debounced level SHALL change only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
REQ-016 Press event: one-cycle pulse when the debounced level goes 1->0; releases generate no event.
REQ-017 S_LO: on a data event, latch iData into oWrData[15:0] and go to S_HI the next cycle.
REQ-018 S_LO: on an address event, load oAddr <= iData[ADDR_WIDTH-1:0] (upper bits of iData ignored if ADDR_WIDTH<16; zero-extended if ADDR_WIDTH>16); stay in S_LO.
REQ-019 S_LO: if data and address events occur in the same cycle, the data event wins and the address event is discarded.
REQ-020 S_HI: on a data event, latch iData into oWrData[31:16], assert oWrEn the next cycle, go to S_WR; address events ignored.
REQ-021 S_WR: oWrEn=1, oAddr and oWrData stable; all key events ignored and lost.
REQ-022 S_WR with iWrAck=1: next cycle oWrEn=0, oAddr <= oAddr+1 (wraps all-ones to 0), oCount <= oCount+1, state S_LO.
REQ-023 iWrAck while oWrEn=0 SHALL be ignored.
REQ-024 No timeout: oWrEn stays high indefinitely until iWrAck.
REQ-025 oWrData is not cleared after a write; its halves are overwritten only by later data events.

Reset
REQ-026 With iReset=1 at a clock edge, the next state SHALL be: state S_LO, oWrEn=0, oAddr=0, oWrData=0, oCount=0, debounced levels=1 (released), debounce counters=0, synchronizers=1.
REQ-027 Reset during S_WR SHALL drop oWrEn in the following cycle; the pending write is abandoned and not counted.
REQ-028 A key held down through reset release SHALL produce one event only after it has been stable low for DEBOUNCE_CYCLES.

Verification (bench uses DEBOUNCE_CYCLES=4)
REQ-029 Basic write: after reset, iData=0x5678 and data press, then iData=0x1234 and data press -> oWrEn=1, oAddr=0, oWrData=0x12345678; ack -> oAddr=1, oCount=1, oState=0.
REQ-030 Bounce rejection: iDataKey toggling every 2 cycles for 20 cycles, then held low 10 cycles -> exactly one event, oState 0->1.
REQ-031 Address load and wrap: iData=0x1FFF with address press (ADDR_WIDTH=13), then write one word -> write at 0x1FFF, then oAddr=0x0000.
REQ-032 Simultaneous events: both keys pass debounce in the same cycle in S_LO with iData=0x00AA -> oWrData[15:0]=0x00AA, oAddr unchanged, oState=1.
REQ-033 Hold and ignore: in S_WR, iWrAck=0 for 50 cycles with 3 data presses -> oWrEn stays 1, oWrData unchanged; after ack, oState=0, no extra half latched.
REQ-034 Reset mid-write: assert iReset for 1 cycle while oWrEn=1 -> next cycle oWrEn=0, oAddr=0, oCount=0, oState=0.
